nibble_serial_add_seq: RTL

//  Upstream sequencer for the 4-bit ripple adder stage (ports A,B,C0 -> F,C4).
//  - Latches one wide operand pair and streams it through that adder one nibble per

---
 rtl/nibble_serial_add_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/nibble_serial_add_seq.sv
// Streams one wide operand pair through an external 4-bit adder, LSB nibble first,
// chaining the carry in a register. Optional SUB_MODE_EN adds a subtract request.
module nibble_serial_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
`ifdef SUB_MODE_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_c0,
    input  logic [3:0]           add_f,
    input  logic                 add_c4,
    output logic [1:0]           state_dbg
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    // Holds every nibble except the top one, which is merged straight into sum.
    logic [W-5:0]   acc;
`ifdef SUB_MODE_EN
    logic           sub_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SUB_MODE_EN
            sub_reg <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        idx   <= '0;
                        state <= S_RUN;
`ifdef SUB_MODE_EN
                        sub_reg <= sub;
                        carry   <= sub ? ~cin : cin;
`else
                        carry   <= cin;
`endif
                    end
                end
                S_RUN: begin
                    carry <= add_c4;
                    if (idx == LAST) begin
                        sum   <= {add_f, acc};
                        cout  <= add_c4;
                        idx   <= '0;
                        state <= S_DONE;
                    end else begin
                        acc[4*idx +: 4] <= add_f;
                        idx <= idx + IW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        add_a  = 4'd0;
        add_b  = 4'd0;
        add_c0 = 1'b0;
        if (state == S_RUN) begin
            add_a  = a_reg[4*idx +: 4];
            add_c0 = carry;
`ifdef SUB_MODE_EN
            add_b  = sub_reg ? ~b_reg[4*idx +: 4] : b_reg[4*idx +: 4];
`else
            add_b  = b_reg[4*idx +: 4];
`endif
        end
    end

    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule
